tff_counter: RTL and testbench
==============================

# tff_counter

Parametrised synchronous counter built from a bank of T flip-flops: each cycle it computes a per-bit toggle vector and toggles the register accordingly. It generalises the single toggle cell to WIDTH bits and adds up/down counting, a programmable modulus, parallel load and wrap signalling. It sits in the sequential library as the standard divider/event-counter primitive, and its toggle vector is exported for debug and verification.

## Interface
- WIDTH, 4: counter width in bits, at least 1.
- MODULUS, 2**WIDTH: count range is 0 to MODULUS-1; valid range is 2 to 2**WIDTH.
- RESET_VAL, 0: value of q after reset; must be below MODULUS.

- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  registered count.
- tog  output  WIDTH  registered copy of the toggle vector applied at the last edge.
- tc  output  1  combinational terminal count: q==MODULUS-1 with up=1, or q==0 with up=0.
- wrap  output  1  registered one-cycle pulse following a wrap.

## Operation
- Priority at each rising edge: rst, then load, then en, then hold.
- **rst:** q=RESET_VAL, tog=0, wrap=0, regardless of the other inputs.
- **load:**
  - q=load_val when load_val<MODULUS; otherwise q=MODULUS-1.
  - tog=q_old XOR q_new; wrap=0; en is ignored.
- **en, up=1:**
  - q<MODULUS-1: q=q+1.
  - q==MODULUS-1: q=0 and wrap=1 on the following cycle.
- **en, up=0:**
  - q>0: q=q-1.
  - q==0: q=MODULUS-1 and wrap=1.
- **Hold (no rst, load or en):** q unchanged, tog=0, wrap=0.
- **Toggle form:**
  - Next state is always applied as q <= q XOR t, where t = target XOR q.
  - For a power-of-two MODULUS, t reduces to the classic form: bit i toggles when all lower bits are 1 (up) or all lower bits are 0 (down).
- **Width rules:** all compares are unsigned WIDTH-bit; no intermediate result may exceed WIDTH bits, e.g. MODULUS-1 is held in WIDTH bits.
- **Direction change:** up may change on any cycle and takes effect at the next enabled edge.

## Timing
- Latency: one cycle from a sampled input to q, tog and wrap.
- tc is combinational from q and up; there is no registered version.
- wrap is high for exactly one cycle per wrap event. With en held high across consecutive wraps (MODULUS=2), wrap stays high on back-to-back cycles.
- load and en together in one cycle: the load wins, with no count and no wrap.
- rst asserted mid-count: the next edge gives q=RESET_VAL. A wrap pending from the previous edge is cleared at that same edge.
- Outputs are valid from the first edge with rst=1; values before the first reset are unspecified.

## Configuration
- Macro: TFF_COUNTER_SAT_EN.
- **Defined:** the counter saturates instead of wrapping.
  - up=1 at MODULUS-1 holds MODULUS-1.
  - up=0 at 0 holds 0.
  - tog=0 on a saturated edge.
  - wrap is tied to 0; tc still asserts at the bound.
- **Undefined:** wrap-around behaviour as described in Operation.

## Test plan
All scenarios use WIDTH=4, MODULUS=10, RESET_VAL=0.
- Reset: rst=1 for 2 cycles with en=1, load=1, load_val=7. Required: q=0, tog=0, wrap=0 after each edge.
- Up wrap: en=1, up=1 for 12 cycles from 0. Required:
  - q runs 1..9, 0, 1, 2.
  - tc=1 only while q=9.
  - wrap=1 only in the cycle where q=0 first reappears.
  - tog=4'b1001 on the 9→0 edge.
- Down wrap: load 1, then en=1, up=0 for 3 cycles. Required:
  - q runs 1, 0, 9, 8.
  - wrap pulses once, coincident with q=9.
  - tog=4'b1001 on the 0→9 edge.
- Load: load=1, en=1, load_val=4'd6 gives q=6 and tog=4'b0110 from q=0. Then load_val=4'd13 gives q=9 (clamped), with wrap=0 on both edges.
- Reset and hold: rst at q=9 while en=1, up=1 gives q=0 and wrap=0 on the next cycle. Then en=0 for 3 cycles: q stays 0 and tog=0.
- Saturation, with TFF_COUNTER_SAT_EN defined: 12 up-counts from 0 give q=9 held from cycle 9 onward, wrap=0 throughout and tog=0 while held. Down-counts from 0 keep q at 0.

Source files
------------

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - WIDTH-bit T flip-flop counter: up/down, modulus, load, wrap pulse.
// Optional saturation instead of wrap-around: define TFF_COUNTER_SAT_EN.
module tff_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2**WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] tog,
  output logic             tc,
  output logic             wrap
);

  // MODULUS-1 fits in WIDTH bits even when MODULUS itself is 2**WIDTH.
  localparam logic [WIDTH-1:0] max_q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] reset_q = WIDTH'(RESET_VAL);
  localparam bit               is_pow2 = (MODULUS == (2**WIDTH));

  logic             at_bound;
  logic [WIDTH-1:0] chain_t;
  logic [WIDTH-1:0] step_t;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] t_next;
  logic             wrap_next;

  assign at_bound = up ? (q == max_q) : (q == '0);
  assign tc       = at_bound;

  // Classic ripple toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    chain_t    = '0;
    chain_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chain_t[i] = chain_t[i-1] & (up ? q[i-1] : ~q[i-1]);
    end
  end

  always_comb begin
    step_t = '0;
    if (is_pow2) begin
      step_t = chain_t;
    end else begin
      step_t = (up ? (q + WIDTH'(1)) : (q - WIDTH'(1))) ^ q;
    end
  end

  always_comb begin
    target    = q;
    t_next    = '0;
    wrap_next = 1'b0;
    if (load) begin
      target = (load_val > max_q) ? max_q : load_val;
      t_next = target ^ q;
    end else if (en) begin
      if (at_bound) begin
`ifdef TFF_COUNTER_SAT_EN
        t_next = '0;
`else
        target    = up ? '0 : max_q;
        t_next    = target ^ q;
        wrap_next = 1'b1;
`endif
      end else begin
        t_next = step_t;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= reset_q;
      tog  <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q ^ t_next;
      tog  <= t_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - directed bench for tff_counter at WIDTH=4, MODULUS=10.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] load_val;
  logic [3:0] q, tog;
  logic       tc, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  tff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tog(tog), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; up = 1; load = 1; load_val = 4'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q[%0d] got %0d exp 0", i, q); end
      n_checks++; if (tog !== 4'd0) begin n_fail++; $display("FAIL reset_tog[%0d] got %b exp 0000", i, tog); end
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap[%0d] got %b exp 0", i, wrap); end
    end
    rst = 0; load = 0; en = 0;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_q [12];
    logic [3:0] prev;
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    prev = 4'd0;
    en = 1; up = 1; load = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL up_q[%0d] got %0d exp %0d", i, q, exp_q[i]); end
      n_checks++; if (tc !== (exp_q[i] == 4'd9)) begin n_fail++; $display("FAIL up_tc[%0d] got %b exp %b", i, tc, exp_q[i] == 4'd9); end
      n_checks++; if (wrap !== (i == 9)) begin n_fail++; $display("FAIL up_wrap[%0d] got %b exp %b", i, wrap, i == 9); end
      n_checks++; if (tog !== (prev ^ exp_q[i])) begin n_fail++; $display("FAIL up_tog[%0d] got %b exp %b", i, tog, prev ^ exp_q[i]); end
      prev = exp_q[i];
    end
    n_checks++; if (tog !== 4'b0011) begin n_fail++; $display("FAIL up_tog_last got %b exp 0011", tog); end
    en = 0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q [3];
    logic [3:0] exp_t [3];
    exp_q = '{4'd0, 4'd9, 4'd8};
    exp_t = '{4'b0001, 4'b1001, 4'b0001};
    load = 1; load_val = 4'd1; en = 0;
    step();
    n_checks++; if (q !== 4'd1) begin n_fail++; $display("FAIL down_load_q got %0d exp 1", q); end
    load = 0; en = 1; up = 0;
    #1;
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL down_tc_at1 got %b exp 0", tc); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (q !== exp_q[i]) begin n_fail++; $display("FAIL down_q[%0d] got %0d exp %0d", i, q, exp_q[i]); end
      n_checks++; if (wrap !== (i == 1)) begin n_fail++; $display("FAIL down_wrap[%0d] got %b exp %b", i, wrap, i == 1); end
      n_checks++; if (tog !== exp_t[i]) begin n_fail++; $display("FAIL down_tog[%0d] got %b exp %b", i, tog, exp_t[i]); end
      n_checks++; if (tc !== (i == 0)) begin n_fail++; $display("FAIL down_tc[%0d] got %b exp %b", i, tc, i == 0); end
    end
    en = 0;
  endtask

  task automatic test_load();
    rst = 1; step(); rst = 0;
    load = 1; en = 1; up = 1; load_val = 4'd6;
    step();
    n_checks++; if (q !== 4'd6) begin n_fail++; $display("FAIL load_q got %0d exp 6", q); end
    n_checks++; if (tog !== 4'b0110) begin n_fail++; $display("FAIL load_tog got %b exp 0110", tog); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap got %b exp 0", wrap); end
    load_val = 4'd13;
    step();
    n_checks++; if (q !== 4'd9) begin n_fail++; $display("FAIL load_clamp_q got %0d exp 9", q); end
    n_checks++; if (tog !== 4'b1111) begin n_fail++; $display("FAIL load_clamp_tog got %b exp 1111", tog); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_clamp_wrap got %b exp 0", wrap); end
    load = 0; en = 0;
  endtask

  task automatic test_reset_hold();
    rst = 1; en = 1; up = 1;
    step();
    n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL rsthold_q got %0d exp 0", q); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL rsthold_wrap got %b exp 0", wrap); end
    rst = 0; load = 1; load_val = 4'd9; step(); load = 0;
    step();
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL pend_wrap_set got %b exp 1", wrap); end
    rst = 1; step(); rst = 0;
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL pend_wrap_clr got %b exp 0", wrap); end
    en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL hold_q[%0d] got %0d exp 0", i, q); end
      n_checks++; if (tog !== 4'd0) begin n_fail++; $display("FAIL hold_tog[%0d] got %b exp 0000", i, tog); end
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL hold_wrap[%0d] got %b exp 0", i, wrap); end
    end
  endtask

  task automatic test_back_to_back();
    load = 1; load_val = 4'd5; step(); load = 0;
    en = 1; up = 1; step();
    n_checks++; if (q !== 4'd6) begin n_fail++; $display("FAIL dir_up_q got %0d exp 6", q); end
    up = 0; step();
    n_checks++; if (q !== 4'd5) begin n_fail++; $display("FAIL dir_down_q got %0d exp 5", q); end
    n_checks++; if (tog !== 4'b0011) begin n_fail++; $display("FAIL dir_down_tog got %b exp 0011", tog); end
    en = 0;
  endtask

  task automatic test_saturation();
    logic [3:0] exp;
    rst = 1; step(); rst = 0;
    en = 1; up = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp = (i < 9) ? 4'(i + 1) : 4'd9;
      n_checks++; if (q !== exp) begin n_fail++; $display("FAIL sat_up_q[%0d] got %0d exp %0d", i, q, exp); end
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_up_wrap[%0d] got %b exp 0", i, wrap); end
      if (i >= 9) begin
        n_checks++; if (tog !== 4'd0) begin n_fail++; $display("FAIL sat_up_tog[%0d] got %b exp 0000", i, tog); end
        n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL sat_up_tc[%0d] got %b exp 1", i, tc); end
      end
    end
    rst = 1; step(); rst = 0;
    up = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (q !== 4'd0) begin n_fail++; $display("FAIL sat_dn_q[%0d] got %0d exp 0", i, q); end
      n_checks++; if (tog !== 4'd0) begin n_fail++; $display("FAIL sat_dn_tog[%0d] got %b exp 0000", i, tog); end
      n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL sat_dn_wrap[%0d] got %b exp 0", i, wrap); end
    end
    en = 0;
  endtask

  initial begin
    rst = 1; en = 0; up = 1; load = 0; load_val = 4'd0;
    test_reset();
`ifdef TFF_COUNTER_SAT_EN
    test_saturation();
    test_load();
`else
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_reset_hold();
    test_back_to_back();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
